// File: rtl/fetch_pkg.sv
// Shared constants and types for the instruction fetch stage.
package fetch_pkg;

  // PC reset value; also the base address of main memory.
  localparam logic [31:0] START_ADDRESS = 32'h8002_0000;

  // Memory access size encoding for a single word.
  localparam logic [1:0] ACC_WORD = 2'b00;

  // Buffered fetch result at the default 32-bit widths.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] insn;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_if.sv
// Fetch-stage bus: memory read port plus the decode valid/ready handshake.
// master = fetch unit side, slave = memory/decode side.
interface fetch_if #(
  parameter int unsigned ADDRESS_SIZE = 32,
  parameter int unsigned DATA_SIZE    = 32
);

  logic                    insn_valid;
  logic                    insn_ready;
  logic [DATA_SIZE-1:0]    insn;
  logic [ADDRESS_SIZE-1:0] insn_pc;

  logic [ADDRESS_SIZE-1:0] mem_addr;
  logic                    mem_en;
  logic                    mem_wren;
  logic [1:0]              mem_acc_size;
  logic [DATA_SIZE-1:0]    mem_rdata;
  logic                    mem_busy;

  modport master (
    output insn_valid, insn, insn_pc, mem_addr, mem_en, mem_wren, mem_acc_size,
    input  insn_ready, mem_rdata, mem_busy
  );

  modport slave (
    input  insn_valid, insn, insn_pc, mem_addr, mem_en, mem_wren, mem_acc_size,
    output insn_ready, mem_rdata, mem_busy
  );

endinterface

// File: rtl/fetch_fifo.sv
// Small shift-register FIFO. Entry 0 is the head, so the head output comes
// straight from a register and is stable until popped.
module fetch_fifo #(
  parameter type         entry_t = fetch_pkg::fetch_entry_t,
  parameter int unsigned DEPTH   = 2,
  localparam int unsigned CntW   = $clog2(DEPTH + 1),
  localparam int unsigned IdxW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            push,
  input  entry_t          push_data,
  input  logic            pop,
  input  logic            flush,
  output logic            full,
  output logic [CntW-1:0] count,
  output entry_t          head
);

  entry_t          entries_q [DEPTH];
  entry_t          entries_d [DEPTH];
  logic [CntW-1:0] count_q;
  logic [CntW-1:0] count_d;
  logic [IdxW-1:0] wr_idx;

  assign full  = (count_q == CntW'(DEPTH));
  assign count = count_q;
  assign head  = entries_q[0];

  // After a pop the tail slot moves down one, so the push lands at count-1.
  assign wr_idx = pop ? IdxW'(count_q - CntW'(1)) : IdxW'(count_q);

  // Next-state: shift on pop, write on push, clear count on flush.
  always_comb begin
    entries_d = entries_q;
    count_d   = count_q;
    if (flush) begin
      count_d = '0;
    end else begin
      if (pop) begin
        for (int i = 0; i < int'(DEPTH) - 1; i++) begin
          entries_d[i] = entries_q[i + 1];
        end
      end
      if (push) begin
        entries_d[wr_idx] = push_data;
      end
      count_d = count_q + CntW'(push) - CntW'(pop);
    end
  end

  // Storage and occupancy registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      entries_q <= '{default: '0};
      count_q   <= '0;
    end else begin
      entries_q <= entries_d;
      count_q   <= count_d;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues one-word reads to main memory,
// buffers returned words with their PCs and hands them to decode.
module fetch_unit #(
  parameter int unsigned             ADDRESS_SIZE  = 32,
  parameter int unsigned             DATA_SIZE     = 32,
  parameter logic [ADDRESS_SIZE-1:0] START_ADDRESS = fetch_pkg::START_ADDRESS,
  parameter int unsigned             FIFO_DEPTH    = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    redirect,
  input  logic [ADDRESS_SIZE-1:0] redirect_pc,
  fetch_if.master                 bus
);

  import fetch_pkg::*;

  localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1);

  typedef struct packed {
    logic [ADDRESS_SIZE-1:0] pc;
    logic [DATA_SIZE-1:0]    insn;
  } entry_t;

  logic [ADDRESS_SIZE-1:0] pc_q;
  logic [ADDRESS_SIZE-1:0] pc_d;
  logic [ADDRESS_SIZE-1:0] inflight_pc_q;
  logic                    inflight_q;
  logic                    kill_q;
  logic                    kill_d;

  logic                    issue;
  logic                    pop;
  logic                    push;
  logic                    fifo_full;
  logic [CntW-1:0]         count;
  logic [CntW:0]           occupancy;
  entry_t                  push_entry;
  entry_t                  head;

  assign pop = bus.insn_valid && bus.insn_ready;

  // Entries held plus the one still coming back, less the one leaving now.
  assign occupancy = {1'b0, count} + {{CntW{1'b0}}, inflight_q} - {{CntW{1'b0}}, pop};

  assign issue = rst_n && !redirect && !bus.mem_busy
                 && (occupancy < (CntW + 1)'(FIFO_DEPTH));

  // A response arriving during a redirect belongs to the old path.
  assign push = inflight_q && !kill_q && !redirect;

  assign push_entry = '{pc: inflight_pc_q, insn: bus.mem_rdata};

  assign bus.mem_en       = issue;
  assign bus.mem_addr     = pc_q;
  assign bus.mem_wren     = 1'b0;
  assign bus.mem_acc_size = ACC_WORD;
  assign bus.insn_valid   = (count != '0);
  assign bus.insn         = head.insn;
  assign bus.insn_pc      = head.pc;

  // Next PC: redirect wins, otherwise step past the issued word.
  always_comb begin
    pc_d   = pc_q;
    kill_d = 1'b0;
    if (redirect) begin
      pc_d   = {redirect_pc[ADDRESS_SIZE-1:2], 2'b00};
      kill_d = issue;
    end else if (issue) begin
      pc_d = pc_q + ADDRESS_SIZE'(4);
    end
  end

  // PC and in-flight request tracking.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q          <= START_ADDRESS;
      inflight_pc_q <= '0;
      inflight_q    <= 1'b0;
      kill_q        <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      inflight_q <= issue;
      kill_q     <= kill_d;
      if (issue) begin
        inflight_pc_q <= pc_q;
      end
    end
  end

  fetch_fifo #(
    .entry_t (entry_t),
    .DEPTH   (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop && !redirect),
    .flush     (redirect),
    .full      (fifo_full),
    .count     (count),
    .head      (head)
  );

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a one-cycle-latency memory model.
module tb_fetch_unit;

  localparam logic [31:0] Base = 32'h8002_0000;

  logic        clk;
  logic        rst_n;
  logic        redirect;
  logic [31:0] redirect_pc;

  int checks = 0;
  int errors = 0;

  fetch_if #(.ADDRESS_SIZE(32), .DATA_SIZE(32)) bus ();

  fetch_unit dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .bus         (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory contents: three preloaded words, a hash of the address elsewhere.
  function automatic logic [31:0] memf(input logic [31:0] a);
    case (a)
      32'h8002_0000: memf = 32'h1111_1111;
      32'h8002_0004: memf = 32'h2222_2222;
      32'h8002_0008: memf = 32'h3333_3333;
      default:       memf = a ^ 32'h5A5A_0F0F;
    endcase
  endfunction

  // Synchronous read: data for a request in cycle t is on mem_rdata in t+1.
  always @(posedge clk) begin
    if (bus.mem_en) bus.mem_rdata <= memf(bus.mem_addr);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance to the next falling edge and check the no-overflow invariant.
  task automatic tick();
    @(negedge clk);
    if (rst_n) chk("no_push_when_full", 32'(dut.push && dut.u_fifo.full), 32'd0);
  endtask

  initial begin
    rst_n          = 1'b0;
    redirect       = 1'b0;
    redirect_pc    = '0;
    bus.insn_ready = 1'b1;
    bus.mem_busy   = 1'b0;
    bus.mem_rdata  = '0;

    // Reset values
    tick(); tick(); #1;
    chk("rst_valid", 32'(bus.insn_valid), 32'd0);
    chk("rst_mem_en", 32'(bus.mem_en), 32'd0);
    chk("rst_addr", bus.mem_addr, Base);
    chk("rst_insn", bus.insn, 32'd0);
    chk("rst_insn_pc", bus.insn_pc, 32'd0);
    chk("rst_wren", 32'(bus.mem_wren), 32'd0);
    chk("rst_acc", 32'(bus.mem_acc_size), 32'd0);

    // Reset release, streaming with ready high
    tick(); rst_n = 1'b1; #1;
    chk("c0_mem_en", 32'(bus.mem_en), 32'd1);
    chk("c0_addr", bus.mem_addr, Base);
    tick(); #1;
    chk("c1_valid", 32'(bus.insn_valid), 32'd0);
    chk("c1_mem_en", 32'(bus.mem_en), 32'd1);
    chk("c1_addr", bus.mem_addr, Base + 32'd4);
    tick(); #1;
    chk("c2_valid", 32'(bus.insn_valid), 32'd1);
    chk("c2_insn", bus.insn, 32'h1111_1111);
    chk("c2_pc", bus.insn_pc, Base);
    tick(); #1;
    chk("c3_insn", bus.insn, 32'h2222_2222);
    chk("c3_pc", bus.insn_pc, Base + 32'd4);
    tick(); #1;
    chk("c4_insn", bus.insn, 32'h3333_3333);
    chk("c4_pc", bus.insn_pc, Base + 32'd8);

    // Redirect with a request in flight
    tick(); redirect = 1'b1; redirect_pc = 32'h8002_0103; #1;
    chk("redir_mem_en", 32'(bus.mem_en), 32'd0);
    tick(); redirect = 1'b0; #1;
    chk("redir_empty", 32'(bus.insn_valid), 32'd0);
    chk("redir_count", 32'(dut.u_fifo.count), 32'd0);
    chk("redir_issue", 32'(bus.mem_en), 32'd1);
    chk("redir_addr", bus.mem_addr, 32'h8002_0100);
    tick(); #1;
    chk("redir1_valid", 32'(bus.insn_valid), 32'd0);
    chk("redir1_addr", bus.mem_addr, 32'h8002_0104);
    tick(); #1;
    chk("redir2_valid", 32'(bus.insn_valid), 32'd1);
    chk("redir2_pc", bus.insn_pc, 32'h8002_0100);
    chk("redir2_insn", bus.insn, memf(32'h8002_0100));

    // Memory busy for three cycles
    tick(); bus.mem_busy = 1'b1; #1;
    chk("busy0_pc", bus.insn_pc, 32'h8002_0104);
    chk("busy0_mem_en", 32'(bus.mem_en), 32'd0);
    chk("busy0_addr", bus.mem_addr, 32'h8002_010C);
    tick(); #1;
    chk("busy1_mem_en", 32'(bus.mem_en), 32'd0);
    chk("busy1_addr", bus.mem_addr, 32'h8002_010C);
    chk("busy1_pc", bus.insn_pc, 32'h8002_0108);
    tick(); #1;
    chk("busy2_mem_en", 32'(bus.mem_en), 32'd0);
    chk("busy2_addr", bus.mem_addr, 32'h8002_010C);
    chk("busy2_valid", 32'(bus.insn_valid), 32'd0);
    tick(); bus.mem_busy = 1'b0; #1;
    chk("resume_mem_en", 32'(bus.mem_en), 32'd1);
    chk("resume_addr", bus.mem_addr, 32'h8002_010C);
    tick(); #1;
    chk("resume1_addr", bus.mem_addr, 32'h8002_0110);
    tick(); #1;
    chk("resume2_valid", 32'(bus.insn_valid), 32'd1);
    chk("resume2_pc", bus.insn_pc, 32'h8002_010C);
    chk("resume2_insn", bus.insn, memf(32'h8002_010C));

    // Asynchronous reset between edges; hold ready low for the backpressure test
    #2; rst_n = 1'b0; bus.insn_ready = 1'b0; #1;
    chk("arst_valid", 32'(bus.insn_valid), 32'd0);
    chk("arst_mem_en", 32'(bus.mem_en), 32'd0);
    chk("arst_addr", bus.mem_addr, Base);
    chk("arst_insn_pc", bus.insn_pc, 32'd0);
    tick(); tick();
    tick(); rst_n = 1'b1; #1;
    chk("bp0_mem_en", 32'(bus.mem_en), 32'd1);
    chk("bp0_addr", bus.mem_addr, Base);
    tick(); #1;
    chk("bp1_mem_en", 32'(bus.mem_en), 32'd1);
    chk("bp1_addr", bus.mem_addr, Base + 32'd4);
    chk("bp1_valid", 32'(bus.insn_valid), 32'd0);
    tick(); #1;
    chk("bp2_pc", bus.insn_pc, Base);
    chk("bp2_insn", bus.insn, 32'h1111_1111);
    chk("bp2_mem_en", 32'(bus.mem_en), 32'd0);
    chk("bp2_count", 32'(dut.u_fifo.count), 32'd1);
    tick(); #1;
    chk("bp3_count", 32'(dut.u_fifo.count), 32'd2);
    chk("bp3_mem_en", 32'(bus.mem_en), 32'd0);
    tick(); #1;
    chk("bp4_count", 32'(dut.u_fifo.count), 32'd2);
    chk("bp4_pc_stable", bus.insn_pc, Base);
    chk("bp4_mem_en", 32'(bus.mem_en), 32'd0);

    // Drain, then simultaneous push and pop
    tick(); bus.insn_ready = 1'b1; #1;
    chk("drain0_mem_en", 32'(bus.mem_en), 32'd1);
    chk("drain0_addr", bus.mem_addr, Base + 32'd8);
    tick(); #1;
    chk("drain1_pc", bus.insn_pc, Base + 32'd4);
    chk("drain1_insn", bus.insn, 32'h2222_2222);
    chk("drain1_push", 32'(dut.push), 32'd1);
    chk("drain1_count", 32'(dut.u_fifo.count), 32'd1);
    tick(); #1;
    chk("drain2_pc", bus.insn_pc, Base + 32'd8);
    chk("drain2_insn", bus.insn, 32'h3333_3333);
    chk("drain2_count", 32'(dut.u_fifo.count), 32'd1);
    tick(); #1;
    chk("drain3_pc", bus.insn_pc, Base + 32'd12);
    chk("drain3_count", 32'(dut.u_fifo.count), 32'd1);

    // Back-to-back redirects, last one wins; target wraps past the top
    tick(); redirect = 1'b1; redirect_pc = 32'h8002_0200; #1;
    chk("bb0_mem_en", 32'(bus.mem_en), 32'd0);
    tick(); redirect_pc = 32'hFFFF_FFFE; #1;
    chk("bb1_mem_en", 32'(bus.mem_en), 32'd0);
    chk("bb1_valid", 32'(bus.insn_valid), 32'd0);
    chk("bb1_addr", bus.mem_addr, 32'h8002_0200);
    tick(); redirect = 1'b0; #1;
    chk("bb2_mem_en", 32'(bus.mem_en), 32'd1);
    chk("bb2_addr", bus.mem_addr, 32'hFFFF_FFFC);
    chk("bb2_valid", 32'(bus.insn_valid), 32'd0);
    tick(); #1;
    chk("wrap_addr", bus.mem_addr, 32'h0000_0000);
    tick(); #1;
    chk("wrap0_pc", bus.insn_pc, 32'hFFFF_FFFC);
    chk("wrap0_insn", bus.insn, memf(32'hFFFF_FFFC));
    tick(); #1;
    chk("wrap1_pc", bus.insn_pc, 32'h0000_0000);
    chk("wrap1_insn", bus.insn, memf(32'h0000_0000));

    tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
